// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream side (in_*) and downstream side (out_*).
// The master modport is the environment around the stage; the slave modport is the stage itself.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 146
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: main register drives the output, skid register absorbs one beat of
// backpressure so in_ready can come straight from a flop. Flush bubbles the stage; stall cycles are counted.
module pipe_skid_stage #(
  parameter int DATA_W         = 146,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  pipe_skid_stage_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_p1, state_nxt;
  logic              in_ready_p1;
  logic [DATA_W-1:0] main_p1;
  logic [DATA_W-1:0] skid_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;

  logic in_fire, accept, vld_p1;
  logic load_main, main_from_skid, load_skid, clear_payload;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vld_p1        = (state_p1 != EMPTY);
  assign in_fire       = bus.in_valid & in_ready_p1;
  assign accept        = vld_p1 & bus.out_ready & ~hold;
  assign clear_payload = flush && (CLEAR_ON_FLUSH != 0);

  always_comb begin
    state_nxt      = state_p1;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && accept) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (accept) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain of main can happen
          if (accept) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---- stage boundary: control, payload and stall counter registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= EMPTY;
      in_ready_p1  <= 1'b1;
      main_p1      <= '0;
      skid_p1      <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      state_p1    <= state_nxt;
      in_ready_p1 <= (state_nxt != FULL);
      if (clear_payload) begin
        main_p1 <= '0;
        skid_p1 <= '0;
      end else begin
        if (load_main) main_p1 <= main_from_skid ? skid_p1 : bus.in_data;
        if (load_skid) skid_p1 <= bus.in_data;
      end
      if (vld_p1 && !accept) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.in_ready  = in_ready_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = main_p1;
  assign occupancy     = state_p1;
  assign stall_cnt     = stall_cnt_p1;

endmodule
